// File: rtl/a2d_intf.sv
// SPI master for the 8-channel 12-bit A2D: sends a channel command, waits a gap,
// reads back the conversion result and presents it on res with a sticky cnv_cmplt.
module a2d_intf #(
  parameter int unsigned GAP_CLKS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        a2d_SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] res,
  output logic        cnv_cmplt
);

  localparam int unsigned DIV_W  = 5;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned GAP_W  = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [DIV_W-1:0] DIV_IDLE = 5'b10111;
  localparam logic [DIV_W-1:0] DIV_SMPL = 5'b10001;
  localparam logic [DIV_W-1:0] DIV_SHFT = 5'b11111;
  localparam logic [CNT_W-1:0] LAST_SMPL = CNT_W'(16);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CLKS - 1);

  typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} state_t;

  state_t              state, nxt_state;
  logic [DIV_W-1:0]    sclk_div;
  logic [CNT_W-1:0]    smpl_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [WORD_W-1:0]   shft;
  logic [WORD_W-1:0]   cmd_word;
  logic [2:0]          chnl_q;
  logic [2:0]          cmd_chnl;
  logic                miso_smpl;
  logic                xfer_end;
  logic                ss_n_set, ss_n_clr, ld_cmd, cap_chnl, clr_cmplt, set_res, gap_clr;

  assign SCLK     = sclk_div[4];
  assign MOSI     = shft[15];
  assign xfer_end = (smpl_cnt == LAST_SMPL) && (sclk_div == DIV_SHFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // Sequencing: command transfer, SS_n-high gap, read transfer, result publish
  always_comb begin
    nxt_state = state;
    ss_n_set  = 1'b0;
    ss_n_clr  = 1'b0;
    ld_cmd    = 1'b0;
    cap_chnl  = 1'b0;
    clr_cmplt = 1'b0;
    set_res   = 1'b0;
    gap_clr   = 1'b0;
    cmd_chnl  = (state == IDLE) ? chnnl : chnl_q;
    cmd_word  = {2'b00, cmd_chnl, 11'h000};
    case (state)
      IDLE: if (strt_cnv) begin
        cap_chnl  = 1'b1;
        ld_cmd    = 1'b1;
        clr_cmplt = 1'b1;
        ss_n_clr  = 1'b1;
        nxt_state = CMD;
      end
      CMD: if (xfer_end) begin
        ss_n_set  = 1'b1;
        gap_clr   = 1'b1;
        nxt_state = GAP;
      end
      GAP: if (gap_cnt == GAP_LAST) begin
        ld_cmd    = 1'b1;
        ss_n_clr  = 1'b1;
        nxt_state = READ;
      end
      READ: if (xfer_end) begin
        ss_n_set  = 1'b1;
        nxt_state = DONE;
      end
      DONE: begin
        set_res   = 1'b1;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        a2d_SS_n <= 1'b1;
    else if (ss_n_set) a2d_SS_n <= 1'b1;
    else if (ss_n_clr) a2d_SS_n <= 1'b0;
  end

  // Divider parks at DIV_IDLE while deselected (and on the closing edge) so SCLK never dips
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    sclk_div <= DIV_IDLE;
    else if (a2d_SS_n || ss_n_set) sclk_div <= DIV_IDLE;
    else                           sclk_div <= sclk_div + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_cnt  <= '0;
      miso_smpl <= 1'b0;
    end else if (a2d_SS_n) begin
      smpl_cnt  <= '0;
    end else if (sclk_div == DIV_SMPL) begin
      smpl_cnt  <= smpl_cnt + CNT_W'(1);
      miso_smpl <= MISO;
    end
  end

  // Shift on SCLK fall, skipping the front-porch fall before any sample exists
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      shft <= '0;
    else if (ld_cmd) shft <= cmd_word;
    else if (!a2d_SS_n && (sclk_div == DIV_SHFT) && (smpl_cnt != '0))
      shft <= {shft[14:0], miso_smpl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              gap_cnt <= '0;
    else if (gap_clr)        gap_cnt <= '0;
    else if (state == GAP)   gap_cnt <= gap_cnt + GAP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        chnl_q <= '0;
    else if (cap_chnl) chnl_q <= chnnl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res       <= '0;
      cnv_cmplt <= 1'b0;
    end else if (set_res) begin
      res       <= shft[11:0];
      cnv_cmplt <= 1'b1;
    end else if (clr_cmplt) begin
      cnv_cmplt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf: SPI slave model, table of conversions, corner sequences.
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt = 1'b0;
  logic        sel = 1'b0;
  logic [2:0]  chnnl = '0;
  logic        MISO;
  logic        ss_a, sclk_a, mosi_a, cmplt_a;
  logic        ss_b, sclk_b, mosi_b, cmplt_b;
  logic [11:0] res_a, res_b;
  logic        strt_a, strt_b;
  logic        m_ss_n, m_sclk, m_mosi, m_cmplt;
  logic [11:0] m_res;

  always #5 clk = ~clk;

  assign strt_a  = strt & ~sel;
  assign strt_b  = strt & sel;
  assign m_ss_n  = sel ? ss_b : ss_a;
  assign m_sclk  = sel ? sclk_b : sclk_a;
  assign m_mosi  = sel ? mosi_b : mosi_a;
  assign m_cmplt = sel ? cmplt_b : cmplt_a;
  assign m_res   = sel ? res_b : res_a;

  a2d_intf dut_a (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_a), .chnnl(chnnl), .MISO(MISO),
    .a2d_SS_n(ss_a), .SCLK(sclk_a), .MOSI(mosi_a), .res(res_a), .cnv_cmplt(cmplt_a)
  );

  a2d_intf #(.GAP_CLKS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_b), .chnnl(chnnl), .MISO(MISO),
    .a2d_SS_n(ss_b), .SCLK(sclk_b), .MOSI(mosi_b), .res(res_b), .cnv_cmplt(cmplt_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // SPI slave: captures MOSI on SCLK rise, advances MISO on falls after the first rise
  logic [15:0] slave_word = '0;
  logic [15:0] tx = '0;
  logic [15:0] rx = '0;
  logic [15:0] cmd_rx = '0;
  logic        seen_rise = 1'b0;
  logic        is_read = 1'b0;
  int          trans_idx = 0;

  assign MISO = tx[15];

  always @(negedge m_ss_n) begin
    is_read   = trans_idx[0];
    trans_idx = trans_idx + 1;
    tx        = is_read ? slave_word : 16'h0000;
    rx        = '0;
    seen_rise = 1'b0;
  end

  always @(posedge m_ss_n) if (!is_read) cmd_rx = rx;

  always @(posedge m_sclk) if (m_ss_n == 1'b0) begin
    rx        = {rx[14:0], m_mosi};
    seen_rise = 1'b1;
  end

  always @(negedge m_sclk) if (m_ss_n == 1'b0 && seen_rise) tx = {tx[14:0], 1'b0};

  // SS_n run-length and SCLK toggle monitor
  int   low_runs[$];
  int   high_runs[$];
  int   run = 0;
  int   sclk_tog = 0;
  logic prev_ss = 1'b1;
  logic prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (m_sclk !== prev_sclk) sclk_tog++;
    prev_sclk = m_sclk;
    if (m_ss_n == 1'b0 && prev_ss) begin
      high_runs.push_back(run);
      run = 0;
    end else if (m_ss_n == 1'b1 && !prev_ss) begin
      low_runs.push_back(run);
      run = 0;
    end
    run++;
    prev_ss = m_ss_n;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_conv(input logic [2:0] ch, input logic [15:0] word,
                          input logic [11:0] exp_res, input logic [15:0] exp_cmd,
                          input logic repulse, input logic exp_prev,
                          input int exp_gap, input int exp_lat);
    int c0;
    slave_word = word;
    trans_idx  = 0;
    low_runs.delete();
    high_runs.delete();
    @(posedge clk); #1;
    strt  = 1'b1;
    chnnl = ch;
    c0    = cyc;
    @(negedge clk);
    chk("cmplt_before_req", int'(m_cmplt), int'(exp_prev));
    @(posedge clk); #1;
    strt  = 1'b0;
    @(negedge clk);
    chk("cmplt_drop", int'(m_cmplt), 0);
    chk("ss_low_start", int'(m_ss_n), 0);
    while (m_cmplt !== 1'b1 && (cyc - c0) < 3000) begin
      strt = repulse && ((cyc - c0) == 200 || (cyc - c0) == 800);
      @(negedge clk);
    end
    strt = 1'b0;
    chk("latency", cyc - c0, exp_lat);
    chk("res", int'(m_res), int'(exp_res));
    chk("cmd_word", int'(cmd_rx), int'(exp_cmd));
    chk("low_run0", low_runs.size() > 0 ? low_runs[0] : -1, 521);
    chk("low_run1", low_runs.size() > 1 ? low_runs[1] : -1, 521);
    chk("gap_run", high_runs.size() > 1 ? high_runs[1] : -1, exp_gap);
    repeat (40) @(negedge clk);
    chk("n_trans", low_runs.size(), 2);
    chk("cmplt_sticky", int'(m_cmplt), 1);
    chk("res_hold", int'(m_res), int'(exp_res));
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic [15:0] word;
    logic [11:0] exp_res;
    logic [15:0] exp_cmd;
    logic        repulse;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3'd5, 16'h0ABC, 12'hABC, 16'h2800, 1'b0};
    vecs[1] = '{3'd0, 16'h0000, 12'h000, 16'h0000, 1'b0};
    vecs[2] = '{3'd1, 16'h0FFF, 12'hFFF, 16'h0800, 1'b0};
    vecs[3] = '{3'd4, 16'h0555, 12'h555, 16'h2000, 1'b0};
    vecs[4] = '{3'd2, 16'h0AAA, 12'hAAA, 16'h1000, 1'b0};
    vecs[5] = '{3'd3, 16'h0001, 12'h001, 16'h1800, 1'b0};
    vecs[6] = '{3'd7, 16'h0800, 12'h800, 16'h3800, 1'b0};
    vecs[7] = '{3'd6, 16'h1234, 12'h234, 16'h3000, 1'b1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sclk_tog = 0;
    repeat (100) @(negedge clk);
    chk("idle_ss", int'(m_ss_n), 1);
    chk("idle_sclk", int'(m_sclk), 1);
    chk("idle_cmplt", int'(m_cmplt), 0);
    chk("idle_res", int'(m_res), 0);
    chk("idle_sclk_toggles", sclk_tog, 0);

    for (int i = 0; i < 8; i++)
      run_conv(vecs[i].ch, vecs[i].word, vecs[i].exp_res, vecs[i].exp_cmd,
               vecs[i].repulse, (i == 0) ? 1'b0 : 1'b1, 32, 1076);

    // Reset in the middle of the command transfer
    begin
      int c0;
      slave_word = 16'h0777;
      @(posedge clk); #1;
      strt  = 1'b1;
      chnnl = 3'd5;
      c0    = cyc;
      @(posedge clk); #1;
      strt  = 1'b0;
      while ((cyc - c0) < 300) @(negedge clk);
      chk("pre_rst_ss", int'(m_ss_n), 0);
      rst_n = 1'b0;
      #1;
      chk("rst_ss", int'(m_ss_n), 1);
      chk("rst_sclk", int'(m_sclk), 1);
      chk("rst_cmplt", int'(m_cmplt), 0);
      chk("rst_res", int'(m_res), 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
    end
    run_conv(3'd5, 16'hF123, 12'h123, 16'h2800, 1'b0, 1'b0, 32, 1076);

    // Short-gap build
    sel = 1'b1;
    repeat (5) @(negedge clk);
    run_conv(3'd2, 16'hF123, 12'h123, 16'h1000, 1'b0, 1'b0, 4, 1048);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a2d_intf.md
Name: a2d_intf

Overview:
- SPI master between the motion controller and the off-board 8-channel 12-bit A2D converter.
- On `strt_cnv`, runs two 16-bit SPI transactions:
  - The first sends the channel command.
  - The second clocks out the conversion result.
- Then presents the 12-bit result on `res` and raises a sticky `cnv_cmplt`.
- The motion controller drives `chnnl` and `strt_cnv`, and consumes `res` (as `A2D_res`) and `cnv_cmplt`.

Parameters:
- GAP_CLKS, 32: clocks `a2d_SS_n` stays high between the command and read transactions (1..255).

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `strt_cnv`, input, 1: one-cycle request to start a conversion.
- `chnnl`, input, 3: A2D channel, captured on the accepted `strt_cnv`.
- `MISO`, input, 1: serial data from the A2D.
- `a2d_SS_n`, output, 1: active-low slave select.
- `SCLK`, output, 1: serial clock, clk/32, idles high.
- `MOSI`, output, 1: serial data to the A2D.
- `res`, output, 12: last conversion result.
- `cnv_cmplt`, output, 1: result valid, sticky.

Behaviour:
- One clock; reset is asynchronous and active-low (`rst_n`). All state registers are reset asynchronously.
- Reset values:
  - `a2d_SS_n`=1, `SCLK`=1, `MOSI`=0, `res`=12'h000, `cnv_cmplt`=0.
  - Shift register=0, FSM in IDLE.
- Reset mid-transaction aborts immediately to these values.
- SCLK generation:
  - A 5-bit divider `sclk_div` is held at 5'b10111 whenever `a2d_SS_n`=1.
  - It increments every clk while `a2d_SS_n`=0.
  - `SCLK` = `sclk_div[4]`.
- Shift register `shft[15:0]`; `MOSI` = `shft[15]`.
- MISO sampling:
  - `MISO` is sampled into a 1-bit holding register in the cycle `sclk_div`==5'b10001 (2 clk after SCLK rise).
  - A 5-bit sample counter increments at each sample.
- Shifting:
  - In the cycle `sclk_div`==5'b11111, `shft` <= {`shft[14:0]`, `miso_smpl`}, coincident with the SCLK fall.
  - This happens only if the sample counter is nonzero, so the front-porch fall does not shift.
- A transaction ends on the cycle where the sample counter==16 and `sclk_div`==5'b11111. That cycle performs the 16th shift; `a2d_SS_n` goes high next cycle.
- Each transaction therefore holds `a2d_SS_n` low for exactly 521 clk: a 9-clk front porch plus 16 SCLK periods of 32 clk.
- Command word: {2'b00, `chnnl`, 11'h000}. It is loaded into `shft` on the accepted `strt_cnv` and reloaded at the start of the second transaction.
- FSM states:
  - IDLE:
    - `strt_cnv`=1: capture `chnnl`, load `shft`, clear `cnv_cmplt`, drive `a2d_SS_n`<=0 -> CMD.
  - CMD: SPI transfer. End condition -> `a2d_SS_n`<=1, clear gap counter -> GAP.
  - GAP: count GAP_CLKS clocks with `a2d_SS_n`=1, `SCLK`=1. On the last count, reload `shft`, `a2d_SS_n`<=0 -> READ.
  - READ: SPI transfer. End condition -> `a2d_SS_n`<=1 -> DONE.
  - DONE (one cycle): `res` <= `shft[11:0]`, `cnv_cmplt` <= 1 -> IDLE.
- Latency with GAP_CLKS=32:
  - `strt_cnv` at cycle 0 -> `a2d_SS_n` low on cycles 1..521 and 554..1074.
  - `res`/`cnv_cmplt` update at the end of cycle 1075; `cnv_cmplt` is first seen high in cycle 1076.
- `cnv_cmplt` stays high until the next accepted `strt_cnv` and drops the cycle after that request.
- `res` holds its value until the next DONE.
- `strt_cnv` outside IDLE is ignored; there is no queueing.
- `strt_cnv` in the same cycle as DONE is also ignored, because the FSM is not yet in IDLE.
- Bits [15:12] of the read word are discarded.

Test Plan:
- Reset, then idle 100 clk -> `a2d_SS_n`=1, `SCLK`=1, `cnv_cmplt`=0, `res`=0, and no SCLK toggles.
- `chnnl`=3'b101 and `strt_cnv` pulse, with the slave model returning 16'h0ABC on the read -> MOSI bits on the 16 SCLK rises of CMD equal 16'h2800; `res`=12'hABC; `cnv_cmplt` first seen high in cycle 1076; `a2d_SS_n` low for 521 clk per transaction with a 32-clk gap.
- Back-to-back conversions on channels 0,1,4,2,3,7 with slave data 12'h000, 12'hFFF, 12'h555, 12'hAAA, 12'h001, 12'h800 -> each `res` matches; `cnv_cmplt` falls one cycle after each `strt_cnv`.
- `strt_cnv` re-pulsed at cycles 200 and 800 during an active conversion -> ignored; exactly two transactions occur, and the result and timing are unchanged.
- Assert `rst_n` low at cycle 300 (mid-CMD) -> `a2d_SS_n`=1, `SCLK`=1, `cnv_cmplt`=0 immediately. A fresh `strt_cnv` after release completes normally.
- Slave returns 16'hF123 -> `res`=12'h123 (upper nibble dropped). Rebuild with GAP_CLKS=4 -> `a2d_SS_n` gap of 4 clk and `cnv_cmplt` first seen high in cycle 1048.
